// File: rtl/amstrad_mem_pkg.sv
// Shared types and constants for the Amstrad external-RAM scheduler.
package amstrad_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 23;
    localparam logic [7:0]  BUS_IDLE   = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VID_LO,
        ST_VID_HI,
        ST_DL,
        ST_CPU
    } state_t;

    typedef enum logic [1:0] {
        REQ_VID,
        REQ_DL,
        REQ_CPU,
        REQ_NONE
    } req_id_t;

    // Fixed priority: video over download over CPU (later assignments win).
    function automatic req_id_t pick_req(input logic vid, input logic dl, input logic cpu);
        req_id_t id;
        id = REQ_NONE;
        if (cpu) id = REQ_CPU;
        if (dl)  id = REQ_DL;
        if (vid) id = REQ_VID;
        return id;
    endfunction

endpackage

// File: rtl/amstrad_mem_slot.sv
// One-deep request holding register with a pending flag.
module amstrad_mem_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         take,
    input  logic [W-1:0] din,
    output logic         pend,
    output logic [W-1:0] dout
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= 1'b0;
            dout <= '0;
        end else begin
            if (take) pend <= 1'b0;
            if (load) begin
                pend <= 1'b1;
                dout <= din;
            end
        end
    end

endmodule

// File: rtl/amstrad_mem_sched.sv
// Arbitrates video, download and CPU accesses onto one byte-wide RAM port,
// with an ack watchdog that completes stalled accesses with idle-bus data.
module amstrad_mem_sched
    import amstrad_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned ACK_TIMEOUT = 63
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cyc1MHz,
    input  logic [14:0]       vid_addr,
    output logic [15:0]       vid_data,
    output logic              vid_valid,
    output logic              vid_late,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              dl_wr,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_busy,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              ram_ack,
    output logic              err
);

    localparam int unsigned WD_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned DL_W  = ADDR_W + 8;
    localparam int unsigned CPU_W = ADDR_W + 9;

    state_t            state, state_d;
    logic [WD_W-1:0]   wd_cnt, wd_d;
    logic              vid_pend, vid_pend_d;
    logic [14:0]       vid_next, vid_next_d;
    logic [14:0]       vid_cur, vid_cur_d;
    logic [7:0]        vid_lo, vid_lo_d;
    logic              req_d, we_d, vvalid_d, vlate_d, ack_d, dlb_d, err_d;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        wdata_d, rdata_d;
    logic [15:0]       vdata_d;

    logic              done, tmo, fin;
    logic [7:0]        rbyte;
    req_id_t           pick;
    logic              vid_take, dl_take, cpu_take, dl_load, cpu_load;
    logic              dl_pend, cpu_pend;
    logic [DL_W-1:0]   dl_q;
    logic [CPU_W-1:0]  cpu_q;

    amstrad_mem_slot #(.W(DL_W)) u_dl_slot (
        .clk   (clk),
        .reset (reset),
        .load  (dl_load),
        .take  (dl_take),
        .din   ({dl_addr, dl_data}),
        .pend  (dl_pend),
        .dout  (dl_q)
    );

    amstrad_mem_slot #(.W(CPU_W)) u_cpu_slot (
        .clk   (clk),
        .reset (reset),
        .load  (cpu_load),
        .take  (cpu_take),
        .din   ({cpu_wr, cpu_addr, cpu_wdata}),
        .pend  (cpu_pend),
        .dout  (cpu_q)
    );

    // Completion: a real ack, or the watchdog expiring while still unacked.
    assign done  = ram_req && ram_ack;
    assign tmo   = ram_req && !ram_ack && (wd_cnt == WD_W'(ACK_TIMEOUT - 1));
    assign fin   = done || tmo;
    assign rbyte = done ? ram_rdata : BUS_IDLE;
    assign pick  = pick_req(vid_pend, dl_pend, cpu_pend);

    assign dl_load  = dl_wr && !dl_busy;
    assign cpu_load = (cpu_rd || cpu_wr) && !cpu_ack && !cpu_pend && (state != ST_CPU);

    always_comb begin
        state_d  = state;
        req_d    = ram_req;
        we_d     = ram_we;
        addr_d   = ram_addr;
        wdata_d  = ram_wdata;
        wd_d     = ram_req ? wd_cnt + WD_W'(1) : wd_cnt;
        vid_cur_d = vid_cur;
        vid_lo_d = vid_lo;
        vdata_d  = vid_data;
        vvalid_d = 1'b0;
        rdata_d  = cpu_rdata;
        ack_d    = cpu_ack;
        dlb_d    = dl_busy;
        err_d    = err || tmo;
        vid_take = 1'b0;
        dl_take  = 1'b0;
        cpu_take = 1'b0;

        unique case (state)
            ST_IDLE: begin
                unique case (pick)
                    REQ_VID: begin
                        state_d   = ST_VID_LO;
                        req_d     = 1'b1;
                        we_d      = 1'b0;
                        addr_d    = ADDR_W'({vid_next, 1'b0});
                        vid_cur_d = vid_next;
                        vid_take  = 1'b1;
                        wd_d      = '0;
                    end
                    REQ_DL: begin
                        state_d = ST_DL;
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        addr_d  = dl_q[DL_W-1:8];
                        wdata_d = dl_q[7:0];
                        dl_take = 1'b1;
                        wd_d    = '0;
                    end
                    REQ_CPU: begin
                        state_d  = ST_CPU;
                        req_d    = 1'b1;
                        we_d     = cpu_q[CPU_W-1];
                        addr_d   = cpu_q[CPU_W-2:8];
                        wdata_d  = cpu_q[7:0];
                        cpu_take = 1'b1;
                        wd_d     = '0;
                    end
                    default: ;
                endcase
            end
            ST_VID_LO: begin
                if (fin) begin
                    req_d    = 1'b0;
                    vid_lo_d = rbyte;
                    state_d  = ST_VID_HI;
                end
            end
            ST_VID_HI: begin
                // Request is low only on entry; ack leaves the state.
                if (!ram_req) begin
                    req_d  = 1'b1;
                    addr_d = ADDR_W'({vid_cur, 1'b1});
                    wd_d   = '0;
                end else if (fin) begin
                    req_d    = 1'b0;
                    vdata_d  = {rbyte, vid_lo};
                    vvalid_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_DL: begin
                if (fin) begin
                    req_d   = 1'b0;
                    dlb_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            ST_CPU: begin
                if (fin) begin
                    req_d   = 1'b0;
                    ack_d   = 1'b1;
                    if (!ram_we || tmo) rdata_d = rbyte;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cpu_ack && !cpu_rd && !cpu_wr) ack_d = 1'b0;
        if (dl_load) dlb_d = 1'b1;

        // A new slot strobe always wins over an unstarted pending fetch.
        vid_pend_d = cyc1MHz ? 1'b1 : (vid_take ? 1'b0 : vid_pend);
        vid_next_d = cyc1MHz ? vid_addr : vid_next;
        vlate_d    = cyc1MHz && (state == ST_VID_LO || state == ST_VID_HI || vid_pend);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wd_cnt    <= '0;
            vid_pend  <= 1'b0;
            vid_next  <= '0;
            vid_cur   <= '0;
            vid_lo    <= '0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            vid_data  <= {BUS_IDLE, BUS_IDLE};
            vid_valid <= 1'b0;
            vid_late  <= 1'b0;
            cpu_rdata <= BUS_IDLE;
            cpu_ack   <= 1'b0;
            dl_busy   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            wd_cnt    <= wd_d;
            vid_pend  <= vid_pend_d;
            vid_next  <= vid_next_d;
            vid_cur   <= vid_cur_d;
            vid_lo    <= vid_lo_d;
            ram_req   <= req_d;
            ram_we    <= we_d;
            ram_addr  <= addr_d;
            ram_wdata <= wdata_d;
            vid_data  <= vdata_d;
            vid_valid <= vvalid_d;
            vid_late  <= vlate_d;
            cpu_rdata <= rdata_d;
            cpu_ack   <= ack_d;
            dl_busy   <= dlb_d;
            err       <= err_d;
        end
    end

endmodule
